// File: rtl/fifo_synchronous_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read port.
module fifo_synchronous_flags #(
   parameter int unsigned SIZE_DATA       = 8,
   parameter int unsigned SIZE_DEPTH      = 16,
   parameter int unsigned ALMOST_FULL_TH  = 14,
   parameter int unsigned ALMOST_EMPTY_TH = 2
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_clr,
   input  logic                            i_wr_en,
   input  logic [SIZE_DATA-1:0]            i_data_wr,
   output logic                            o_full,
   output logic                            o_almost_full,
   input  logic                            i_rd_en,
   output logic [SIZE_DATA-1:0]            o_data_rd,
   output logic                            o_rd_valid,
   output logic                            o_empty,
   output logic                            o_almost_empty,
   output logic [$clog2(SIZE_DEPTH):0]     o_count,
   output logic                            o_overflow,
   output logic                            o_underflow
);

   localparam int unsigned SIZE_PTR = $clog2(SIZE_DEPTH);
   localparam int unsigned SIZE_CNT = SIZE_PTR + 1;

   if ((SIZE_DEPTH < 2) || ((SIZE_DEPTH & (SIZE_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("SIZE_DEPTH must be a power of two and at least 2");
   end
   if ((ALMOST_FULL_TH < 1) || (ALMOST_FULL_TH > SIZE_DEPTH)) begin : g_bad_afull
      $error("ALMOST_FULL_TH must lie in 1..SIZE_DEPTH");
   end
   if (ALMOST_EMPTY_TH > SIZE_DEPTH - 1) begin : g_bad_aempty
      $error("ALMOST_EMPTY_TH must lie in 0..SIZE_DEPTH-1");
   end

   logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];
   logic [SIZE_PTR-1:0]  wr_ptr;
   logic [SIZE_PTR-1:0]  rd_ptr;
   logic [SIZE_CNT-1:0]  count;
   logic [SIZE_CNT-1:0]  count_nxt;
   logic                 wr_acc;
   logic                 rd_acc;

   // Accept decisions use the registered flags; a flush blocks both ports.
   assign wr_acc = i_wr_en & ~o_full & ~i_clr;
   assign rd_acc = i_rd_en & ~o_empty & ~i_clr;

   always_comb begin
      count_nxt = count;
      if (i_clr) begin
         count_nxt = '0;
      end else if (wr_acc && !rd_acc) begin
         count_nxt = count + SIZE_CNT'(1);
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count - SIZE_CNT'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= i_data_wr;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         o_full         <= 1'b0;
         o_empty        <= 1'b1;
         o_almost_full  <= 1'b0;
         o_almost_empty <= 1'b1;
         o_overflow     <= 1'b0;
         o_underflow    <= 1'b0;
      end else begin
         count          <= count_nxt;
         o_full         <= (count_nxt == SIZE_CNT'(SIZE_DEPTH));
         o_empty        <= (count_nxt == '0);
         o_almost_full  <= (count_nxt >= SIZE_CNT'(ALMOST_FULL_TH));
         o_almost_empty <= (count_nxt <= SIZE_CNT'(ALMOST_EMPTY_TH));
         if (i_clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
         end else begin
            if (wr_acc) wr_ptr <= wr_ptr + SIZE_PTR'(1);
            if (rd_acc) rd_ptr <= rd_ptr + SIZE_PTR'(1);
            if (i_wr_en && o_full) o_overflow <= 1'b1;
            if (i_rd_en && o_empty) o_underflow <= 1'b1;
         end
      end
   end

   assign o_count = count;

`ifdef FIFO_FWFT_EN
   // Head word is presented combinationally; i_rd_en only pops it.
   assign o_data_rd  = o_empty ? '0 : mem[rd_ptr];
   assign o_rd_valid = ~o_empty;
`else
   logic [SIZE_DATA-1:0] data_rd;
   logic                 rd_valid;

   // Flush deliberately leaves the last read word in place.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_rd  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) data_rd <= mem[rd_ptr];
      end
   end

   assign o_data_rd  = data_rd;
   assign o_rd_valid = rd_valid;
`endif

endmodule

// File: tb/tb_fifo_synchronous_flags.sv
// Directed self-checking bench for fifo_synchronous_flags in the default registered-read build.
module tb_fifo_synchronous_flags;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       wr_en;
   logic [7:0] data_wr;
   logic       full;
   logic       almost_full;
   logic       rd_en;
   logic [7:0] data_rd;
   logic       rd_valid;
   logic       empty;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_errors = 0;

   fifo_synchronous_flags #(
      .SIZE_DATA      (8),
      .SIZE_DEPTH     (16),
      .ALMOST_FULL_TH (14),
      .ALMOST_EMPTY_TH(2)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_clr         (clr),
      .i_wr_en       (wr_en),
      .i_data_wr     (data_wr),
      .o_full        (full),
      .o_almost_full (almost_full),
      .i_rd_en       (rd_en),
      .o_data_rd     (data_rd),
      .o_rd_valid    (rd_valid),
      .o_empty       (empty),
      .o_almost_empty(almost_empty),
      .o_count       (count),
      .o_overflow    (overflow),
      .o_underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr_en   = w;
      data_wr = d;
      rd_en   = r;
      clr     = c;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
      check({tag, "_full"}, 32'(full), 32'd0);
      check({tag, "_afull"}, 32'(almost_full), 32'd0);
      check({tag, "_count"}, 32'(count), 32'd0);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
      check({tag, "_unf"}, 32'(underflow), 32'd0);
      check({tag, "_valid"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #12;
      rst = 1'b0;
      #3;
      // 1: reset then idle
      step();
      check_reset_state("reset");
      check("reset_data", 32'(data_rd), 32'h00);

      // 2: fill with 0x01..0x10, then overflow attempt
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0);
         step();
         check("fill_count", 32'(count), 32'(i));
         check("fill_afull", 32'(almost_full), 32'(i >= 14));
         check("fill_full", 32'(full), 32'(i == 16));
         check("fill_empty", 32'(empty), 32'd0);
         check("fill_aempty", 32'(almost_empty), 32'(i <= 2));
      end
      drive(1'b1, 8'hFF, 1'b0, 1'b0);
      step();
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd16);
      check("ovf_full", 32'(full), 32'd1);

      // 3: drain, first word proves the 0xFF write was dropped
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         step();
         check("drain_valid", 32'(rd_valid), 32'd1);
         check("drain_data", 32'(data_rd), 32'(i));
         check("drain_count", 32'(count), 32'(16 - i));
         check("drain_aempty", 32'(almost_empty), 32'((16 - i) <= 2));
         check("drain_empty", 32'(empty), 32'(i == 16));
         check("drain_ovf_sticky", 32'(overflow), 32'd1);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      step();
      check("idle_valid", 32'(rd_valid), 32'd0);
      check("idle_hold", 32'(data_rd), 32'h10);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      check("unf_set", 32'(underflow), 32'd1);
      check("unf_valid", 32'(rd_valid), 32'd0);
      check("unf_hold", 32'(data_rd), 32'h10);
      check("unf_count", 32'(count), 32'd0);

      // 4: advance pointers to 10, then stream across the wrap at count 1
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
         step();
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         step();
         check("pre_wrap_data", 32'(data_rd), 32'(8'h20 + i));
      end
      drive(1'b1, 8'hA0, 1'b0, 1'b0);
      step();
      check("wrap_start_count", 32'(count), 32'd1);
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
         step();
         check("wrap_count", 32'(count), 32'd1);
         check("wrap_data", 32'(data_rd), 32'(8'hA0 + i - 1));
         check("wrap_valid", 32'(rd_valid), 32'd1);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      check("wrap_last", 32'(data_rd), 32'hAA);
      check("wrap_empty", 32'(empty), 32'd1);

      // 5: flush at count 8 with both requests asserted
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
         step();
      end
      check("pre_clr_count", 32'(count), 32'd8);
      check("pre_clr_unf", 32'(underflow), 32'd1);
      drive(1'b1, 8'h77, 1'b1, 1'b1);
      step();
      check_reset_state("clr");
      check("clr_hold", 32'(data_rd), 32'hAA);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      step();
      check("post_clr_count", 32'(count), 32'd0);
      drive(1'b1, 8'h33, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      check("post_clr_data", 32'(data_rd), 32'h33);
      check("post_clr_empty", 32'(empty), 32'd1);

      // 6: asynchronous reset mid-burst at count 5
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      check("pre_rst_count", 32'(count), 32'd4);
      check("pre_rst_valid", 32'(rd_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("arst");
      check("arst_data", 32'(data_rd), 32'h00);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      drive(1'b1, 8'h5A, 1'b0, 1'b0);
      step();
      check("rst_wr_count", 32'(count), 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      check("rst_rd_data", 32'(data_rd), 32'h5A);
      check("rst_rd_valid", 32'(rd_valid), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
